// File: rtl/cu_pkg.sv
// Shared encodings for control_unit_fsm: opcodes, FSM states, branch kinds and
// instruction field offsets (layout MSB first: OPC[4], FS[4], DA, AA, BA).
package cu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ALU  = 4'd1;
  localparam logic [3:0] OP_ALUI = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_BZ   = 4'd5;
  localparam logic [3:0] OP_BN   = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_CALL = 4'd8;
  localparam logic [3:0] OP_RET  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } cu_state_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_Z    = 3'd1,
    BR_N    = 3'd2,
    BR_JMP  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } br_type_e;

  function automatic int inst_w(input int ra_w);  return 8 + 3 * ra_w; endfunction
  function automatic int ba_lsb(input int ra_w);  return 0 * ra_w;     endfunction
  function automatic int aa_lsb(input int ra_w);  return ra_w;         endfunction
  function automatic int da_lsb(input int ra_w);  return 2 * ra_w;     endfunction
  function automatic int fs_lsb(input int ra_w);  return 3 * ra_w;     endfunction
  function automatic int opc_lsb(input int ra_w); return 3 * ra_w + 4; endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decode: datapath strobes and branch kind from opcode + FSM state.
// CALL/RET decode only exists when CU_CALL_STACK_EN is defined.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [3:0] opc_i,
  input  cu_state_e  state_i,
  input  logic       dack_i,
  output logic       mb_o,
  output logic       md_o,
  output logic       rw_o,
  output logic       mw_o,
  output logic       dreq_o,
  output logic       illegal_o,
  output br_type_e   br_o
);

  always_comb begin
    mb_o      = 1'b0;
    md_o      = 1'b0;
    rw_o      = 1'b0;
    mw_o      = 1'b0;
    dreq_o    = 1'b0;
    illegal_o = 1'b0;
    br_o      = BR_NONE;
    case (state_i)
      S_EXEC: begin
        case (opc_i)
          OP_NOP, OP_HALT: ;
          OP_ALU:  rw_o = 1'b1;
          OP_ALUI: begin rw_o = 1'b1; mb_o = 1'b1; end
          OP_LD:   begin dreq_o = 1'b1; md_o = 1'b1; end
          OP_ST:   begin dreq_o = 1'b1; mw_o = 1'b1; end
          OP_BZ:   br_o = BR_Z;
          OP_BN:   br_o = BR_N;
          OP_JMP:  br_o = BR_JMP;
`ifdef CU_CALL_STACK_EN
          OP_CALL: br_o = BR_CALL;
          OP_RET:  br_o = BR_RET;
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      // MEM is only reachable from LD/ST; the write-back pulse lands on the DACK cycle
      S_MEM: begin
        dreq_o = 1'b1;
        if (opc_i == OP_LD) begin
          md_o = 1'b1;
          rw_o = dack_i;
        end else begin
          mw_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT sequencer holding PC and IR.
// Define CU_CALL_STACK_EN to add CALL/RET with a STACK_DEPTH-entry return stack.
module control_unit_fsm
  import cu_pkg::*;
#(
  parameter int RA_W        = 2,
  parameter int PC_W        = 4,
  parameter int DATA_W      = 4,
  parameter int STACK_DEPTH = 4
)(
  input  logic                CLK,
  input  logic                RST_N,
  output logic                IREQ,
  input  logic                IACK,
  input  logic [8+3*RA_W-1:0] INST,
  output logic [PC_W-1:0]     PC,
  output logic                DREQ,
  input  logic                DACK,
  input  logic                Z,
  input  logic                N,
  input  logic [DATA_W-1:0]   A_BUS,
  output logic [RA_W-1:0]     DA,
  output logic [RA_W-1:0]     AA,
  output logic [RA_W-1:0]     BA,
  output logic                MB,
  output logic                MD,
  output logic                RW,
  output logic                MW,
  output logic [3:0]          FS,
  output logic [DATA_W-1:0]   CONSTANT,
  output logic                HALTED,
  output logic                ILLEGAL,
  output logic                STACK_ERR
);

  localparam int INST_W = inst_w(RA_W);
  localparam int OPC_L  = opc_lsb(RA_W);
  localparam int FS_L   = fs_lsb(RA_W);
  localparam int DA_L   = da_lsb(RA_W);
  localparam int AA_L   = aa_lsb(RA_W);
  localparam int BA_L   = ba_lsb(RA_W);

  cu_state_e         state_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] ir_q;
  logic              live_q;
  logic              in_ex;
  logic [3:0]        ir_opc, ir_fs;
  logic [RA_W-1:0]   ir_da, ir_aa, ir_ba;
  logic [31:0]       off_d;
  logic [PC_W-1:0]   br_tgt_d, stk_pc_d;
  br_type_e          br;
  logic              unused_bits;

  assign ir_opc = ir_q[OPC_L +: 4];
  assign ir_fs  = ir_q[FS_L +: 4];
  assign ir_da  = ir_q[DA_L +: RA_W];
  assign ir_aa  = ir_q[AA_L +: RA_W];
  assign ir_ba  = ir_q[BA_L +: RA_W];

  // {DA,BA} is a two's-complement offset relative to the already-incremented PC
  assign off_d    = {{(32-2*RA_W){ir_da[RA_W-1]}}, ir_da, ir_ba};
  assign br_tgt_d = pc_q + off_d[PC_W-1:0];

  cu_decoder u_dec (
    .opc_i     (ir_opc),
    .state_i   (state_q),
    .dack_i    (DACK),
    .mb_o      (MB),
    .md_o      (MD),
    .rw_o      (RW),
    .mw_o      (MW),
    .dreq_o    (DREQ),
    .illegal_o (ILLEGAL),
    .br_o      (br)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_FETCH: begin
          if (IREQ && IACK) begin
            ir_q    <= INST;
            pc_q    <= pc_q + 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ir_opc == OP_HALT) state_q <= S_HALT;
          else if (DREQ)         state_q <= S_MEM;
          else                   state_q <= S_FETCH;
          case (br)
            BR_Z:            if (Z) pc_q <= br_tgt_d;
            BR_N:            if (N) pc_q <= br_tgt_d;
            BR_JMP:          pc_q <= A_BUS[PC_W-1:0];
            BR_CALL, BR_RET: pc_q <= stk_pc_d;
            default: ;
          endcase
        end
        S_MEM: if (DACK) state_q <= S_FETCH;
        default: ;
      endcase
    end
  end

`ifdef CU_CALL_STACK_EN
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0]  stk_q [STACK_DEPTH];
  logic [SP_W-1:0]  top_q, top_inc, top_dec;
  logic [CNT_W-1:0] cnt_q;
  logic             serr_q;
  logic [31:0]      call_tgt;
  logic             unused_stk;

  // top_q is the next free slot; when full it coincides with the oldest entry
  assign top_inc  = (top_q == SP_W'(STACK_DEPTH-1)) ? '0 : top_q + 1'b1;
  assign top_dec  = (top_q == '0) ? SP_W'(STACK_DEPTH-1) : top_q - 1'b1;
  assign call_tgt = 32'({ir_aa, ir_ba});
  assign stk_pc_d = (br == BR_CALL) ? call_tgt[PC_W-1:0] :
                    (cnt_q == '0)   ? '0 : stk_q[top_dec];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      top_q  <= '0;
      cnt_q  <= '0;
      serr_q <= 1'b0;
    end else if (br == BR_CALL) begin
      stk_q[top_q] <= pc_q;
      top_q        <= top_inc;
      if (cnt_q == CNT_W'(STACK_DEPTH)) serr_q <= 1'b1;
      else                              cnt_q  <= cnt_q + 1'b1;
    end else if (br == BR_RET) begin
      if (cnt_q == '0) begin
        serr_q <= 1'b1;
      end else begin
        top_q <= top_dec;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign STACK_ERR  = serr_q;
  assign unused_stk = ^call_tgt;
`else
  localparam int unused_depth = STACK_DEPTH;
  assign stk_pc_d  = '0;
  assign STACK_ERR = 1'b0;
`endif

  assign unused_bits = ^{A_BUS, off_d};

  assign in_ex    = (state_q == S_EXEC) || (state_q == S_MEM);
  assign DA       = in_ex ? ir_da : '0;
  assign AA       = in_ex ? ir_aa : '0;
  assign BA       = in_ex ? ir_ba : '0;
  assign FS       = in_ex ? ir_fs : '0;
  assign CONSTANT = in_ex ? DATA_W'(ir_ba) : '0;
  // live_q keeps IREQ low in the first cycle out of reset
  assign IREQ     = live_q && (state_q == S_FETCH);
  assign HALTED   = (state_q == S_HALT);
  assign PC       = pc_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: vector table, corner sequences and
// random programs against an instruction-level reference model.
module tb_control_unit_fsm;

  localparam int RA_W = 2, PC_W = 4, DATA_W = 4, STACK_DEPTH = 4;
  localparam int INST_W = 8 + 3*RA_W;
  localparam int PC_MOD = 1 << PC_W;
`ifdef CU_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic CLK = 1'b0, RST_N = 1'b0, IACK = 1'b0, DACK = 1'b0, Z = 1'b0, N = 1'b0;
  logic [INST_W-1:0] INST = '0;
  logic [DATA_W-1:0] A_BUS = '0;
  logic IREQ, DREQ, MB, MD, RW, MW, HALTED, ILLEGAL, STACK_ERR;
  logic [PC_W-1:0] PC;
  logic [RA_W-1:0] DA, AA, BA;
  logic [3:0] FS;
  logic [DATA_W-1:0] CONSTANT;

  control_unit_fsm #(.RA_W(RA_W), .PC_W(PC_W), .DATA_W(DATA_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IREQ(IREQ), .IACK(IACK), .INST(INST), .PC(PC),
    .DREQ(DREQ), .DACK(DACK), .Z(Z), .N(N), .A_BUS(A_BUS), .DA(DA), .AA(AA), .BA(BA),
    .MB(MB), .MD(MD), .RW(RW), .MW(MW), .FS(FS), .CONSTANT(CONSTANT),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL), .STACK_ERR(STACK_ERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  int m_pc;
  int m_stk[$];
  logic m_err;
  logic [7:0] snap_ctl;
  logic [3:0] snap_fs;
  logic [DATA_W-1:0] snap_const;
  int snap_dreq;

  typedef struct {
    logic [INST_W-1:0] inst;
    logic z, n;
    logic [DATA_W-1:0] ab;
    logic [7:0] ctl;
    logic [3:0] fs;
    logic [DATA_W-1:0] cst;
    logic [PC_W-1:0] pc;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ctl();
    return {RW, MB, MD, MW, DREQ, ILLEGAL, HALTED, IREQ};
  endfunction

  function automatic logic [INST_W-1:0] mk(input int op, input int fs, input int da, input int aa, input int ba);
    logic [3:0] o, f;
    logic [RA_W-1:0] d, a, b;
    o = op[3:0]; f = fs[3:0]; d = da[RA_W-1:0]; a = aa[RA_W-1:0]; b = ba[RA_W-1:0];
    return {o, f, d, a, b};
  endfunction

  // Expected EXEC-cycle strobes straight from the opcode table
  function automatic logic [7:0] exp_exec(input int op);
    logic legal;
    legal = (op <= 7) || (op == 15) || (STK && (op == 8 || op == 9));
    return {(op == 1 || op == 2), (op == 2), (op == 3), (op == 4), (op == 3 || op == 4), !legal, 1'b0, 1'b0};
  endfunction

  function automatic int wrap(input int x);
    return ((x % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  task automatic model_exec(input int op, input int da, input int aa, input int ba,
                            input logic z, input logic n, input int ab);
    int off;
    off = da * (1 << RA_W) + ba;
    if (off >= (1 << (2*RA_W-1))) off -= (1 << (2*RA_W));
    case (op)
      5: if (z) m_pc = wrap(m_pc + off);
      6: if (n) m_pc = wrap(m_pc + off);
      7: m_pc = wrap(ab);
      8: if (STK) begin
           m_stk.push_back(m_pc);
           if (m_stk.size() > STACK_DEPTH) begin void'(m_stk.pop_front()); m_err = 1'b1; end
           m_pc = wrap(aa * (1 << RA_W) + ba);
         end
      9: if (STK) begin
           if (m_stk.size() == 0) begin m_pc = 0; m_err = 1'b1; end
           else m_pc = m_stk.pop_back();
         end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    RST_N = 1'b0; IACK = 1'b0; DACK = 1'b0; INST = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ctl", ctl(), 0);
    chk("rst_pc", PC, 0);
    chk("rst_fields", {DA, AA, BA, FS, CONSTANT, STACK_ERR}, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    m_pc = 0; m_stk.delete(); m_err = 1'b0;
  endtask

  task automatic wait_ireq();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 8; g++) begin
      @(negedge CLK);
      if (IREQ) begin seen = 1'b1; break; end
      @(posedge CLK); #1;
    end
    chk("ireq_wait", seen, 1);
  endtask

  // Runs one instruction through fetch/exec/mem with the given handshake delays
  task automatic run_instr(input logic [INST_W-1:0] inst, input int iw, input int dw,
                           input logic z, input logic n, input logic [DATA_W-1:0] ab);
    int op, fs, da, aa, ba, dcnt, rcnt;
    op = int'(inst[INST_W-1 -: 4]);
    fs = int'(inst[INST_W-5 -: 4]);
    da = int'(inst[3*RA_W-1 -: RA_W]);
    aa = int'(inst[2*RA_W-1 -: RA_W]);
    ba = int'(inst[RA_W-1:0]);
    wait_ireq();
    for (int i = 0; i < iw; i++) begin
      chk("fetch_stall_ctl", ctl(), 8'h01);
      chk("fetch_stall_pc", PC, m_pc);
      @(posedge CLK); #1;
      @(negedge CLK);
    end
    IACK = 1'b1; INST = inst;
    chk("fetch_ctl", ctl(), 8'h01);
    chk("fetch_pc", PC, m_pc);
    chk("fetch_fields", {DA, AA, BA, FS}, 0);
    @(posedge CLK); #1;
    IACK = 1'b0; INST = INST_W'($urandom);
    Z = z; N = n; A_BUS = ab;
    m_pc = wrap(m_pc + 1);
    @(negedge CLK);
    snap_ctl = ctl(); snap_fs = FS; snap_const = CONSTANT;
    chk("exec_ctl", snap_ctl, exp_exec(op));
    chk("exec_fields", {DA, AA, BA, FS}, {da[RA_W-1:0], aa[RA_W-1:0], ba[RA_W-1:0], fs[3:0]});
    chk("exec_const", CONSTANT, ba);
    chk("exec_pc", PC, m_pc);
    dcnt = int'(DREQ); rcnt = int'(RW);
    @(posedge CLK); #1;
    if (op == 3 || op == 4) begin
      for (int i = 0; i < dw; i++) begin
        @(negedge CLK);
        chk("mem_wait_ctl", ctl(), {1'b0, 1'b0, (op == 3), (op == 4), 1'b1, 3'b000});
        chk("mem_wait_pc", PC, m_pc);
        chk("mem_wait_da", DA, da);
        dcnt += int'(DREQ); rcnt += int'(RW);
        @(posedge CLK); #1;
      end
      DACK = 1'b1;
      @(negedge CLK);
      chk("mem_ack_ctl", ctl(), {(op == 3), 1'b0, (op == 3), (op == 4), 1'b1, 3'b000});
      dcnt += int'(DREQ); rcnt += int'(RW);
      @(posedge CLK); #1;
      DACK = 1'b0;
      chk("mem_dreq_cycles", dcnt, dw + 2);
      chk("mem_rw_pulses", rcnt, (op == 3) ? 1 : 0);
    end
    snap_dreq = dcnt;
    model_exec(op, da, aa, ba, z, n, int'(ab));
    if (op != 15) begin
      @(negedge CLK);
      chk("pc_after", PC, m_pc);
      chk("stack_err", STACK_ERR, m_err);
      chk("after_rw", RW, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tg[5];
    int rets[5];

    vt.push_back('{inst: mk(1, 5, 1, 2, 3), z: 0, n: 0, ab: 0, ctl: 8'h80, fs: 5, cst: 3, pc: 1});
    vt.push_back('{inst: mk(2, 9, 0, 1, 3), z: 0, n: 0, ab: 0, ctl: 8'hC0, fs: 9, cst: 3, pc: 1});
    vt.push_back('{inst: mk(0, 0, 0, 0, 0), z: 1, n: 1, ab: 7, ctl: 8'h00, fs: 0, cst: 0, pc: 1});
    vt.push_back('{inst: mk(3, 0, 2, 1, 1), z: 0, n: 0, ab: 0, ctl: 8'h28, fs: 0, cst: 1, pc: 1});
    vt.push_back('{inst: mk(4, 0, 0, 3, 2), z: 0, n: 0, ab: 0, ctl: 8'h18, fs: 0, cst: 2, pc: 1});
    vt.push_back('{inst: mk(5, 0, 0, 0, 3), z: 1, n: 0, ab: 0, ctl: 8'h00, fs: 0, cst: 3, pc: 4});
    vt.push_back('{inst: mk(5, 0, 0, 0, 3), z: 0, n: 1, ab: 0, ctl: 8'h00, fs: 0, cst: 3, pc: 1});
    vt.push_back('{inst: mk(6, 0, 3, 0, 3), z: 0, n: 1, ab: 0, ctl: 8'h00, fs: 0, cst: 3, pc: 0});
    vt.push_back('{inst: mk(7, 0, 0, 0, 0), z: 0, n: 0, ab: 9, ctl: 8'h00, fs: 0, cst: 0, pc: 9});
    vt.push_back('{inst: mk(10, 0, 1, 1, 1), z: 0, n: 0, ab: 0, ctl: 8'h04, fs: 0, cst: 1, pc: 1});
    vt.push_back('{inst: mk(14, 3, 0, 0, 2), z: 1, n: 1, ab: 0, ctl: 8'h04, fs: 3, cst: 2, pc: 1});
`ifndef CU_CALL_STACK_EN
    vt.push_back('{inst: mk(8, 0, 0, 2, 1), z: 0, n: 0, ab: 0, ctl: 8'h04, fs: 0, cst: 1, pc: 1});
    vt.push_back('{inst: mk(9, 0, 0, 0, 0), z: 0, n: 0, ab: 0, ctl: 8'h04, fs: 0, cst: 0, pc: 1});
`endif

    foreach (vt[i]) begin
      do_reset();
      run_instr(vt[i].inst, 0, 0, vt[i].z, vt[i].n, vt[i].ab);
      chk("vec_ctl", snap_ctl, vt[i].ctl);
      chk("vec_fs", snap_fs, vt[i].fs);
      chk("vec_const", snap_const, vt[i].cst);
      chk("vec_pc", PC, vt[i].pc);
    end

    // LD whose DACK comes three cycles after DREQ first rises
    do_reset();
    run_instr(mk(3, 0, 1, 2, 0), 1, 2, 1'b0, 1'b0, '0);
    chk("ld_stall_dreq_cycles", snap_dreq, 4);
    chk("ld_stall_pc", PC, 1);

    // BZ at PC=15: fetch wraps PC to 0, offset -2 lands on 14
    do_reset();
    run_instr(mk(7, 0, 0, 0, 0), 0, 0, 1'b0, 1'b0, 4'd15);
    chk("jmp_to_15", PC, 15);
    run_instr(mk(5, 0, 3, 0, 2), 0, 0, 1'b1, 1'b0, '0);
    chk("bz_wrap_taken", PC, 14);
    do_reset();
    run_instr(mk(7, 0, 0, 0, 0), 0, 0, 1'b0, 1'b0, 4'd15);
    run_instr(mk(5, 0, 3, 0, 2), 0, 0, 1'b0, 1'b0, '0);
    chk("bz_wrap_not_taken", PC, 0);

    // HALT holds indefinitely even with a fetch being offered
    do_reset();
    run_instr(mk(15, 0, 0, 0, 0), 0, 0, 1'b0, 1'b0, '0);
    IACK = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("halt_ctl", ctl(), 8'h02);
      chk("halt_pc", PC, 1);
      @(posedge CLK); #1;
    end
    IACK = 1'b0;

    // Reset dropped while a load is waiting in MEM
    do_reset();
    wait_ireq();
    IACK = 1'b1; INST = mk(3, 0, 1, 0, 0);
    @(posedge CLK); #1;
    IACK = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mem_before_rst", ctl(), 8'h28);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_ctl", ctl(), 0);
    chk("async_rst_fields", {DA, AA, BA, FS, CONSTANT}, 0);
    chk("async_rst_pc", PC, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    m_pc = 0; m_stk.delete(); m_err = 1'b0;

`ifdef CU_CALL_STACK_EN
    // Five nested CALLs overflow a 4-deep stack; five RETs unwind then underflow
    tg = '{3, 5, 7, 9, 11};
    rets = '{10, 8, 6, 4, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_instr(mk(8, 0, 0, tg[i] >> RA_W, tg[i] % (1 << RA_W)), 0, 0, 1'b0, 1'b0, '0);
      chk("call_pc", PC, tg[i]);
    end
    chk("stack_overflow_err", STACK_ERR, 1);
    for (int i = 0; i < 5; i++) begin
      run_instr(mk(9, 0, 0, 0, 0), 0, 0, 1'b0, 1'b0, '0);
      chk("ret_pc", PC, rets[i]);
    end
`else
    tg = '{0, 0, 0, 0, 0};
    rets = tg;
`endif

    // Random program with random handshake delays
    do_reset();
    for (int i = 0; i < 150; i++) begin
      run_instr(mk($urandom_range(0, 14), $urandom_range(0, 15), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3)),
                $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                DATA_W'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit.
- Fetches instructions from an external instruction memory over a req/ack handshake and decodes them into datapath controls (DA/AA/BA/MB/FS/MD/RW/MW/CONSTANT).
- Stalls on data-memory loads and stores.
- Handles conditional branches, register jumps, illegal opcodes and HALT.
- Sits between the instruction/data memories and the existing register-file/ALU datapath.

Parameters:
- RA_W, 2, register address width (DA/AA/BA fields).
- PC_W, 4, program counter width.
- DATA_W, 4, datapath width; CONSTANT is zero-extended to this width.
- STACK_DEPTH, 4, return-stack entries. Used only with CU_CALL_STACK_EN.
- Derived: INST_W = 8+3*RA_W.
- Instruction layout, MSB first: OPC[4], FS[4], DA, AA, BA.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- IREQ  out  1  instruction fetch request.
- IACK  in  1  instruction valid; INST is sampled when IREQ&&IACK.
- INST  in  INST_W  instruction word.
- PC  out  PC_W  fetch address.
- DREQ  out  1  data-memory request (LD/ST).
- DACK  in  1  data-memory completion.
- Z, N  in  1 each  ALU zero/negative flags, sampled in EXEC.
- A_BUS  in  DATA_W  register A value; low PC_W bits form the JMP target.
- DA, AA, BA  out  RA_W each  register addresses.
- MB, MD, RW, MW  out  1 each  datapath controls.
- FS  out  4  ALU function select.
- CONSTANT  out  DATA_W  zero-extended BA field.
- HALTED  out  1  high in HALT state.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- STACK_ERR  out  1  sticky flag. Tied 0 without CU_CALL_STACK_EN.

Behaviour:
- States: FETCH, EXEC, MEM, HALT.
- Reset: async on RST_N low. Goes to FETCH; PC=0; IR=0; all outputs 0 (RW/MW/DREQ/IREQ/ILLEGAL/HALTED/STACK_ERR all 0).
- FETCH:
  - IREQ=1.
  - On IACK: IR<=INST, PC<=PC+1 (mod 2^PC_W), go to EXEC.
  - No IACK: hold, no PC change.
- EXEC: decoded controls come from IR; IR fields DA/AA/BA/FS drive outputs whenever the FSM is in EXEC or MEM, otherwise 0.
  - 0 NOP: no control asserted. Next state FETCH.
  - 1 ALU: RW=1, MB=0, MD=0. Next state FETCH.
  - 2 ALUI: RW=1, MB=1. Next state FETCH.
  - 3 LD: DREQ=1, MD=1. Next state MEM.
  - 4 ST: DREQ=1, MW=1. Next state MEM.
  - 5 BZ: if Z, PC<=PC+sext({DA,BA}). Next state FETCH.
  - 6 BN: same as BZ with N.
  - 7 JMP: PC<=A_BUS[PC_W-1:0]. Next state FETCH.
  - 15 HALT: next state HALT.
  - Any other opcode: ILLEGAL=1 for one cycle, treated as NOP.
- MEM:
  - Hold DREQ, MD/MW and addresses until DACK.
  - LD: on the DACK cycle, RW=1 (single-cycle pulse), then FETCH.
  - ST: MW drops on the DACK cycle's exit, then FETCH.
- Register write pulses are exactly one cycle. RW is never asserted in FETCH.
- Branch arithmetic:
  - The offset is 2*RA_W bits, two's complement, sign-extended to PC_W (truncated if wider).
  - It is added to the already-incremented PC, wrapping mod 2^PC_W.
- HALT: HALTED=1; IREQ=0; no outputs change. Left only by reset.
- Reset mid-handshake (IREQ or DREQ outstanding): abandon immediately. No RW pulse is issued.
- Minimum cycles per instruction: 2 (ALU/branch with zero-wait IACK); 3 (LD/ST with zero-wait DACK).

Optional Feature:
- Macro: CU_CALL_STACK_EN.
- Defined:
  - Opcode 8 CALL pushes the incremented PC and loads PC<={AA,BA} zero-extended.
  - Opcode 9 RET pops into PC.
  - The stack has STACK_DEPTH entries.
  - Push when full overwrites the oldest entry and sets STACK_ERR.
  - Pop when empty sets PC=0 and STACK_ERR.
  - STACK_ERR is cleared only by reset.
- Undefined: opcodes 8/9 are illegal (ILLEGAL pulse, NOP); STACK_ERR=0; no stack storage.

Decomposition:
- Package cu_pkg:
  - opcode localparams (OP_NOP … OP_HALT, OP_CALL, OP_RET);
  - state encoding;
  - field-offset functions of RA_W.
- Sub-module cu_decoder: purely combinational, IR and state in; MB/MD/RW/MW/DREQ/ILLEGAL and a branch-type code out.
- Top level holds the FSM, PC, IR and the optional stack.

Test Plan:
- Reset then IACK=1 with INST=ALU(FS=5, DA=1, AA=2, BA=3): cycle 2 shows RW=1, FS=5, DA=1, MB=0; PC=1.
- ALUI with BA=3, DATA_W=4: CONSTANT=4'b0011, MB=1, RW=1 one cycle.
- LD with DACK delayed 3 cycles: DREQ/MD held 4 cycles; RW pulses only on the DACK cycle; PC does not advance during the stall.
- PC=15 (PC_W=4) executing BZ with Z=1, offset -2: PC wraps to 0 after fetch, then becomes 14. Same with Z=0: PC=0.
- Opcode 10 → ILLEGAL pulses one cycle, no RW/MW. HALT → HALTED=1, IREQ=0 for 20 cycles. RST_N low mid-MEM → all outputs 0 asynchronously.
- With CU_CALL_STACK_EN, STACK_DEPTH=4: 5 nested CALLs set STACK_ERR. 5 RETs return correctly for the 4 stored entries; the final RET gives PC=0.
